// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/grant/read-return bundle between the cores and the
// arbiter, plus the single command port into the shared data memory.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CORES  = 4
);
  logic [NUM_CORES-1:0]              core_req;
  logic [NUM_CORES-1:0]              core_we;
  logic [NUM_CORES*ADDR_WIDTH-1:0]   core_addr;
  logic [NUM_CORES*2*DATA_WIDTH-1:0] core_wdata;
  logic [NUM_CORES-1:0]              core_gnt;
  logic [NUM_CORES-1:0]              core_rvalid;
  logic [DATA_WIDTH-1:0]             core_rdata;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [2*DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]             mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input  core_gnt, core_rvalid, core_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin grant of one core command per cycle onto the shared
// memory, with read data routed back 2 cycles after grant. MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CORES  = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_CORES);
  localparam int WW = 2*DATA_WIDTH;

  logic [NUM_CORES-1:0]  gnt_q, gnt_d, rvalid_q, rvalid_d, elig;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]         wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:1]            vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]         own1_q, own1_d, own2_q, own2_d;
  logic                  win_vld;
  logic [PW-1:0]         win;

  // The core currently holding its grant still has req high; masking it avoids a double grant.
  assign elig = bus.core_req & ~gnt_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win     = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;

  // Scan downward so the last hit (nearest to ptr+1) wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      idx = PW'((int'(ptr_q) + i) % NUM_CORES);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
    ptr_d = win_vld ? win : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(NUM_CORES-1);
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    gnt_d      = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    vld_pipe_d = {vld_pipe_q[1], 1'b0};
    own1_d     = own1_q;
    own2_d     = own1_q;
    if (win_vld) begin
      gnt_d[win]    = 1'b1;
      we_d          = bus.core_we[win];
      addr_d        = bus.core_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d       = bus.core_wdata[win*WW +: WW];
      vld_pipe_d[1] = ~bus.core_we[win];
      own1_d        = win;
    end
    // Stage 2 lines up with registered memory read data.
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (vld_pipe_q[2]) begin
      rvalid_d[own2_q] = 1'b1;
      rdata_d          = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vld_pipe_q <= '0;
      own1_q     <= '0;
      own2_q     <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vld_pipe_q <= vld_pipe_d;
      own1_q     <= own1_d;
      own2_q     <= own2_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.core_gnt    = gnt_q;
  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = rdata_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of mem_port_arbiter against a small byte-wide
// memory model with registered read data.
module tb_mem_port_arbiter;
  localparam int DW = 8, AW = 8, NC = 4;

  logic clk, rst_n;
  int   checks = 0, errors = 0;
  logic [DW-1:0] mem [0:255];

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CORES(NC)) bus ();
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CORES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: two-byte write, registered read, modular addr+1.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]              <= bus.mem_wdata[7:0];
      mem[8'(bus.mem_addr + 8'd1)]   <= bus.mem_wdata[15:8];
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
  endtask

  task automatic set_req(input int c, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.core_req[c]           = 1'b1;
    bus.core_we[c]            = we;
    bus.core_addr[c*8 +: 8]   = a;
    bus.core_wdata[c*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Single read by core c; returns in the cycle where rvalid should be high.
  task automatic read_op(input int c, input logic [7:0] a);
    set_req(c, 1'b0, a, 16'h0);
    tick();
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.core_req = 4'($urandom);
    bus.core_we  = 4'($urandom);
    bus.core_addr = 32'($urandom);
    repeat (3) tick();
    checks++; if (bus.core_gnt !== 4'h0) begin errors++; $display("FAIL rst_gnt: got %h expected 0", bus.core_gnt); end
    checks++; if (bus.core_rvalid !== 4'h0) begin errors++; $display("FAIL rst_rvalid: got %h expected 0", bus.core_rvalid); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", bus.mem_wdata); end
    checks++; if (bus.core_rdata !== 8'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.core_rdata); end
    // Async assertion mid-cycle while a write is on the bus.
    clear_reqs();
    rst_n = 1'b1;
    tick();
    set_req(2, 1'b1, 8'h5A, 16'h1111);
    tick();
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL pre_async_we: got %b expected 1", bus.mem_we); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.core_gnt !== 4'h0) begin errors++; $display("FAIL async_gnt: got %h expected 0", bus.core_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL async_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h0) begin errors++; $display("FAIL async_addr: got %h expected 0", bus.mem_addr); end
    do_reset();
  endtask

  task automatic test_write_read();
    set_req(2, 1'b1, 8'h10, 16'hABCD);
    tick();
    checks++; if (bus.core_gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b expected 0100", bus.core_gnt); end
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b expected 1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h expected 10", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'hABCD) begin errors++; $display("FAIL wr_wdata: got %h expected abcd", bus.mem_wdata); end
    clear_reqs();
    tick();
    checks++; if (bus.core_gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_pulse: got %b expected 0000", bus.core_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_pulse: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL idle_addr_hold: got %h expected 10", bus.mem_addr); end
    set_req(0, 1'b0, 8'h10, 16'h0);
    tick();
    checks++; if (bus.core_gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt: got %b expected 0001", bus.core_gnt); end
    clear_reqs();
    tick();
    checks++; if (bus.core_rvalid !== 4'b0000) begin errors++; $display("FAIL rd_early: got %b expected 0000", bus.core_rvalid); end
    tick();
    checks++; if (bus.core_rvalid !== 4'b0001) begin errors++; $display("FAIL rd_rvalid: got %b expected 0001", bus.core_rvalid); end
    checks++; if (bus.core_rdata !== 8'hCD) begin errors++; $display("FAIL rd_lo: got %h expected cd", bus.core_rdata); end
    tick();
    checks++; if (bus.core_rvalid !== 4'b0000) begin errors++; $display("FAIL rd_rvalid_pulse: got %b expected 0000", bus.core_rvalid); end
    checks++; if (bus.core_rdata !== 8'hCD) begin errors++; $display("FAIL rd_hold: got %h expected cd", bus.core_rdata); end
    read_op(0, 8'h11);
    checks++; if (bus.core_rdata !== 8'hAB || bus.core_rvalid !== 4'b0001) begin errors++; $display("FAIL rd_hi: got %h/%b expected ab/0001", bus.core_rdata, bus.core_rvalid); end
    tick();
  endtask

  task automatic test_all_four();
    logic [7:0] exp_d [4];
    logic [3:0] exp_g, exp_rv;
    exp_d = '{8'hCD, 8'hAB, 8'hCD, 8'hAB};
    do_reset();
    for (int c = 0; c < 4; c++) set_req(c, 1'b0, (c % 2 == 0) ? 8'h10 : 8'h11, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_g  = (c <= 4) ? 4'(1 << (c-1)) : 4'h0;
      exp_rv = (c >= 3) ? 4'(1 << (c-3)) : 4'h0;
      checks++; if (bus.core_gnt !== exp_g) begin errors++; $display("FAIL all4_gnt c%0d: got %b expected %b", c, bus.core_gnt, exp_g); end
      checks++; if (bus.core_rvalid !== exp_rv) begin errors++; $display("FAIL all4_rvalid c%0d: got %b expected %b", c, bus.core_rvalid, exp_rv); end
      if (c >= 3) begin
        checks++; if (bus.core_rdata !== exp_d[c-3]) begin errors++; $display("FAIL all4_rdata c%0d: got %h expected %h", c, bus.core_rdata, exp_d[c-3]); end
      end
      bus.core_req = bus.core_req & ~bus.core_gnt;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [6];
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
`endif
    do_reset();
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 8'h10, 16'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (bus.core_gnt !== exp_seq[k]) begin errors++; $display("FAIL rr_gnt k%0d: got %b expected %b", k, bus.core_gnt, exp_seq[k]); end
    end
    clear_reqs();
    repeat (4) tick();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(1, 1'b0, 8'h11, 16'h0);
    tick();
    checks++; if (bus.core_gnt !== 4'b0010) begin errors++; $display("FAIL inflight_gnt: got %b expected 0010", bus.core_gnt); end
    clear_reqs();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.core_rvalid !== 4'b0000) begin errors++; $display("FAIL inflight_rvalid k%0d: got %b expected 0000", k, bus.core_rvalid); end
    end
    set_req(0, 1'b0, 8'h10, 16'h0);
    set_req(3, 1'b0, 8'h10, 16'h0);
    tick();
    checks++; if (bus.core_gnt !== 4'b0001) begin errors++; $display("FAIL post_rst_prio: got %b expected 0001", bus.core_gnt); end
    clear_reqs();
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    set_req(3, 1'b1, 8'hFF, 16'h1234);
    tick();
    checks++; if (bus.core_gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt: got %b expected 1000", bus.core_gnt); end
    checks++; if (bus.mem_addr !== 8'hFF || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wrap_cmd: got %h/%b expected ff/1", bus.mem_addr, bus.mem_we); end
    clear_reqs();
    tick();
    read_op(0, 8'hFF);
    checks++; if (bus.core_rdata !== 8'h34 || bus.core_rvalid !== 4'b0001) begin errors++; $display("FAIL wrap_lo: got %h/%b expected 34/0001", bus.core_rdata, bus.core_rvalid); end
    tick();
    read_op(2, 8'h00);
    checks++; if (bus.core_rdata !== 8'h12 || bus.core_rvalid !== 4'b0100) begin errors++; $display("FAIL wrap_hi: got %h/%b expected 12/0100", bus.core_rdata, bus.core_rvalid); end
    tick();
  endtask

  task automatic test_back_to_back_raw();
    set_req(0, 1'b1, 8'h40, 16'h7788);
    tick();
    checks++; if (bus.core_gnt !== 4'b0001) begin errors++; $display("FAIL raw_wgnt: got %b expected 0001", bus.core_gnt); end
    clear_reqs();
    set_req(1, 1'b0, 8'h40, 16'h0);
    tick();
    checks++; if (bus.core_gnt !== 4'b0010 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL raw_rgnt: got %b/%b expected 0010/0", bus.core_gnt, bus.mem_we); end
    clear_reqs();
    tick();
    tick();
    checks++; if (bus.core_rvalid !== 4'b0010 || bus.core_rdata !== 8'h88) begin errors++; $display("FAIL raw_data: got %b/%h expected 0010/88", bus.core_rvalid, bus.core_rdata); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_write_read();
    test_all_four();
    test_round_robin();
    test_reset_inflight();
    test_wrap();
    test_back_to_back_raw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the shared data memory and is the only block that drives its write-enable, address and write-data inputs.
- Accepts read/write requests from NUM_CORES multiplier cores, grants one per cycle using round-robin, and drives a single memory command.
- Returns the memory's registered 8-bit read data to the requesting core with a valid pulse.

Parameters:
DATA_WIDTH, 8, memory word width; write data is 2*DATA_WIDTH (two bytes per write).
ADDR_WIDTH, 8, memory address width.
NUM_CORES, 4, number of requesting cores (2..8).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
core_req  input  NUM_CORES  per-core request, held high until core_gnt seen.
core_we  input  NUM_CORES  per-core op: 1 = write, 0 = read; stable while req high.
core_addr  input  NUM_CORES*ADDR_WIDTH  packed per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
core_wdata  input  NUM_CORES*2*DATA_WIDTH  packed per-core write data; low byte to addr, high byte to addr+1.
core_gnt  output  NUM_CORES  one-hot, one-cycle pulse: request accepted and issued this cycle.
core_rvalid  output  NUM_CORES  one-hot, one-cycle pulse: core_rdata valid for that core.
core_rdata  output  DATA_WIDTH  shared read-return data.
mem_we  output  1  memory write enable.
mem_addr  output  ADDR_WIDTH  drives both write and read address of memory.
mem_wdata  output  2*DATA_WIDTH  memory write data.
mem_rdata  input  DATA_WIDTH  memory registered read data.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0. The round-robin pointer is set to NUM_CORES-1, so core 0 has top priority first. The read-owner pipeline is cleared. A read in flight at reset never produces core_rvalid.
- Cycle A (arbitrate): the eligible set is core_req & ~core_gnt. The core currently seeing its grant is masked, which prevents a double grant while it still holds req. The winner is the first eligible core searching from pointer+1 modulo NUM_CORES upward.
- End of cycle A: if there is a winner w, register core_gnt = 1<<w, mem_we = core_we[w], mem_addr = core_addr[w], mem_wdata = core_wdata[w], pointer = w. If w issued a read, record owner w in read stage 1.
- Cycle A+1: core_gnt[w] is high and the command is on the mem_* outputs. The memory acts at the end of A+1. On a write, memory bytes addr and addr+1 are updated.
- Cycle A+2: mem_rdata is valid, and the owner moves to read stage 2. At the end of A+2, core_rdata <= mem_rdata and core_rvalid <= 1<<owner.
- Cycle A+3: core_rvalid[w] = 1 for one cycle. Read latency is 2 cycles after core_gnt.
- Idle (no eligible core): core_gnt = 0 and mem_we = 0. mem_addr and mem_wdata hold their last values. core_rdata holds its last value when rvalid = 0.
- Throughput: one command per cycle overall, and at most one grant every two cycles per core.
- Read-after-write to the same address issued on consecutive cycles returns the new data.
- Address wrap: a write to 2**ADDR_WIDTH-1 is forwarded unchanged. The high byte lands at address 0 (modular), with no error flag.
- Simultaneous events: a grant, a read return, and a read return for the same core can all coexist in one cycle. They use independent outputs.
- Requests that change while waiting for a grant are a protocol violation; the arbiter samples whatever is present in the arbitration cycle.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins among eligible cores. The pointer register is removed. Starvation of high indices is possible.
- Undefined: round-robin as specified above.
- The grant mask and all timing are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random core_req -> core_gnt, core_rvalid, mem_we, mem_addr, mem_wdata and core_rdata are all 0. Assert rst_n=0 mid-cycle -> outputs clear immediately (async).
- Core 2 writes addr 0x10, data 0xABCD -> next cycle core_gnt=0b0100, mem_we=1, mem_addr=0x10, mem_wdata=0xABCD for exactly one cycle. Core 0 then reads 0x10 -> core_rvalid=0b0001 two cycles after its gnt with core_rdata=0xCD; a read of 0x11 returns 0xAB.
- All four cores request reads together from reset, each deasserting on its gnt -> grants 0,1,2,3 on consecutive cycles, and rvalid follows in the same order 2 cycles behind each gnt.
- Cores 0,1,2 request continuously -> round-robin build grants 0,1,2,0,1,2. The MEM_ARB_FIXED_PRIO_EN build grants 0,1,0,1, and core 2 never receives a grant.
- Core 1 read granted, rst_n pulsed low on the cycle after its gnt -> no core_rvalid ever appears. After release, core 0 has first priority.
- Core 3 writes addr 0xFF, data 0x1234 -> mem_addr=0xFF, mem_we=1. Subsequent reads of 0xFF and 0x00 return 0x34 and 0x12.
